// File: rtl/invaders_pkg.sv
// Shared constants, FSM state type and scoring helper for the invaders
// collision logic.
package invaders_pkg;

    localparam int DEF_ROWS      = 5;
    localparam int DEF_COLS      = 11;
    localparam int DEF_ALIEN_W   = 16;
    localparam int DEF_ALIEN_H   = 8;
    localparam int DEF_COL_PITCH = 24;
    localparam int DEF_ROW_PITCH = 16;
    localparam int DEF_MISSILE_W = 2;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    function automatic logic [5:0] row_points(input logic [2:0] row);
        case (row)
            3'd0:       return 6'd30;
            3'd1, 3'd2: return 6'd20;
            default:    return 6'd10;
        endcase
    endfunction

endpackage

// File: rtl/alien_box_overlap.sv
// Combinational box test between the missile and one alien cell.
// Operands are widened to 11 bits so that no sum can wrap.
module alien_box_overlap
    import invaders_pkg::*;
#(
    parameter int ALIEN_W   = DEF_ALIEN_W,
    parameter int ALIEN_H   = DEF_ALIEN_H,
    parameter int MISSILE_W = DEF_MISSILE_W
) (
    input  logic [9:0]  i_mx,
    input  logic [9:0]  i_my,
    input  logic [9:0]  i_msize,
    input  logic [10:0] i_ax,
    input  logic [10:0] i_ay,
    output logic        o_overlap
);

    logic [10:0] w_mx;
    logic [10:0] w_my;
    logic [10:0] w_msize;

    assign w_mx    = {1'b0, i_mx};
    assign w_my    = {1'b0, i_my};
    assign w_msize = {1'b0, i_msize};

    assign o_overlap = (w_mx < i_ax + 11'(ALIEN_W)) &&
                       (w_mx + 11'(MISSILE_W) > i_ax) &&
                       (w_my < i_ay + 11'(ALIEN_H)) &&
                       (w_my + w_msize > i_ay);

endmodule

// File: rtl/missile_collider.sv
// Per-frame missile/alien collision scan: one cell per cycle, first live
// overlapping alien is killed and scored.
module missile_collider
    import invaders_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int ALIEN_W   = DEF_ALIEN_W,
    parameter int ALIEN_H   = DEF_ALIEN_H,
    parameter int COL_PITCH = DEF_COL_PITCH,
    parameter int ROW_PITCH = DEF_ROW_PITCH,
    parameter int MISSILE_W = DEF_MISSILE_W
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_tick,
    input  logic                 wave_reset,
    input  logic [9:0]           missilex,
    input  logic [9:0]           missiley,
    input  logic [9:0]           missilesize,
    input  logic [9:0]           gridx,
    input  logic [9:0]           gridy,
    output logic [ROWS*COLS-1:0] alive,
    output logic                 hit,
    output logic [2:0]           hit_row,
    output logic [3:0]           hit_col,
    output logic                 score_inc,
    output logic [5:0]           score_pts,
    output logic                 busy,
    output logic                 all_dead
);

    localparam int NCELLS = ROWS * COLS;
    localparam int IDXW   = $clog2(NCELLS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDXW-1:0]     r_idx;
    logic [2:0]          r_row;
    logic [3:0]          r_col;
    logic [10:0]         r_ax;
    logic [10:0]         r_ay;
    logic [9:0]          r_gx;
    logic [9:0]          r_mx;
    logic [9:0]          r_my;
    logic [9:0]          r_msz;
    logic [NCELLS-1:0]   r_alive;
    logic                r_hit;
    logic [2:0]          r_hit_row;
    logic [3:0]          r_hit_col;
    logic                r_score_inc;
    logic [5:0]          r_score_pts;
    logic                r_all_dead;

    logic w_overlap;
    logic w_parked;
    logic w_last;
    logic w_accept;
    logic w_kill;

    // Cell origin is tracked incrementally instead of multiplying row/col.
    alien_box_overlap #(
        .ALIEN_W   (ALIEN_W),
        .ALIEN_H   (ALIEN_H),
        .MISSILE_W (MISSILE_W)
    ) u_overlap (
        .i_mx      (r_mx),
        .i_my      (r_my),
        .i_msize   (r_msz),
        .i_ax      (r_ax),
        .i_ay      (r_ay),
        .o_overlap (w_overlap)
    );

    // Same value the latched copies will hold; checked on the raw inputs
    // so the decision is made in the accepting cycle.
    assign w_parked = (missilex >= 10'(SCREEN_W)) || (missiley >= 10'(SCREEN_H));
    assign w_last   = (r_idx == IDXW'(NCELLS - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_kill      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_tick) begin
                    w_accept = 1'b1;
                    if (!w_parked) w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (r_alive[r_idx] && w_overlap) begin
                    w_kill      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (wave_reset) begin
            w_state_nxt = ST_IDLE;
            w_accept    = 1'b0;
            w_kill      = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_idx       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_ax        <= '0;
            r_ay        <= '0;
            r_gx        <= '0;
            r_mx        <= '0;
            r_my        <= '0;
            r_msz       <= '0;
            r_alive     <= '1;
            r_hit       <= 1'b0;
            r_hit_row   <= '0;
            r_hit_col   <= '0;
            r_score_inc <= 1'b0;
            r_score_pts <= '0;
            r_all_dead  <= 1'b0;
        end else begin
            r_score_inc <= 1'b0;
            r_all_dead  <= (r_alive == '0);
            if (wave_reset) begin
                r_alive <= '1;
                r_hit   <= 1'b0;
            end else if (w_accept) begin
                r_hit <= 1'b0;
                r_mx  <= missilex;
                r_my  <= missiley;
                r_msz <= missilesize;
                r_gx  <= gridx;
                r_idx <= '0;
                r_row <= '0;
                r_col <= '0;
                r_ax  <= {1'b0, gridx};
                r_ay  <= {1'b0, gridy};
            end else if (w_kill) begin
                r_alive[r_idx] <= 1'b0;
                r_hit          <= 1'b1;
                r_hit_row      <= r_row;
                r_hit_col      <= r_col;
                r_score_inc    <= 1'b1;
                r_score_pts    <= row_points(r_row);
            end else if (r_state == ST_SCAN) begin
                r_idx <= r_idx + 1'b1;
                if (r_col == 4'(COLS - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + 3'd1;
                    r_ax  <= {1'b0, r_gx};
                    r_ay  <= r_ay + 11'(ROW_PITCH);
                end else begin
                    r_col <= r_col + 4'd1;
                    r_ax  <= r_ax + 11'(COL_PITCH);
                end
            end
        end
    end

    assign alive     = r_alive;
    assign hit       = r_hit;
    assign hit_row   = r_hit_row;
    assign hit_col   = r_hit_col;
    assign score_inc = r_score_inc;
    assign score_pts = r_score_pts;
    assign busy      = (r_state == ST_SCAN);
    assign all_dead  = r_all_dead;

endmodule

// File: doc/missile_collider.md
# missile_collider

Per-frame collision stage between the alien formation and the player missile. Once per frame it scans every alien cell, tests its bounding box against the missile box, and kills the first overlapping live alien. It then drives the `hit` level that the missile block samples on its next `frame_clk` edge, and pulses a score increment to the score block. It sits downstream of the missile block (consumes `missilex`/`missiley`/`missilesize`) and feeds `hit` back into it.

## Interface
Parameters:
- `ROWS`, 5: formation rows.
- `COLS`, 11: formation columns.
- `ALIEN_W`, 16: alien box width, px.
- `ALIEN_H`, 8: alien box height, px.
- `COL_PITCH`, 24: horizontal cell pitch, px.
- `ROW_PITCH`, 16: vertical cell pitch, px.
- `MISSILE_W`, 2: missile width, px.

Ports (one clock `Clk`; reset `Reset` is asynchronous, active-high):
- `Clk`  in  1: system clock.
- `Reset`  in  1: async active-high reset.
- `frame_tick`  in  1: one-`Clk` pulse at each frame boundary.
- `wave_reset`  in  1: sync; revive all aliens.
- `missilex`, `missiley`  in  10 each: missile top-left.
- `missilesize`  in  10: missile height.
- `gridx`, `gridy`  in  10 each: formation top-left.
- `alive`  out  ROWS*COLS: bit `r*COLS+c` = alien (r,c) alive.
- `hit`  out  1: kill occurred this frame (level).
- `hit_row`  out  3: row of last kill.
- `hit_col`  out  4: column of last kill.
- `score_inc`  out  1: one-cycle kill pulse.
- `score_pts`  out  6: points for the kill, valid with `score_inc`.
- `busy`  out  1: scan in progress.
- `all_dead`  out  1: registered, 1 when `alive == 0`.

## Operation
- FSM states: IDLE, SCAN.
- IDLE, `frame_tick`=1:
  - clear `hit`;
  - latch missile and grid inputs;
  - if latched `missilex >= 640` or `missiley >= 480` (missile parked off-screen), stay in IDLE;
  - otherwise set `idx = 0` and go to SCAN.
- SCAN, one cell per cycle in ascending `idx`, with `row = idx / COLS`, `col = idx % COLS`:
  - `ax = gridx + col*COL_PITCH`, `ay = gridy + row*ROW_PITCH`.
  - Overlap when all hold: `mx < ax+ALIEN_W`, `mx+MISSILE_W > ax`, `my < ay+ALIEN_H`, `my+missilesize > ay`.
  - All sums use 11-bit unsigned arithmetic; no wrap.
  - On alive and overlap: clear the alive bit, set `hit`=1, load `hit_row`/`hit_col`, pulse `score_inc`, load `score_pts`, go to IDLE. At most one kill per frame; the lowest index wins.
  - On `idx == ROWS*COLS-1` with no kill: go to IDLE.
- Points by row: row 0 = 30, rows 1–2 = 20, rows 3–4 = 10.
- `hit` holds from the kill until the next accepted `frame_tick`, so it is stable across a `frame_clk` edge.
- `frame_tick` during SCAN is ignored; no queueing.
- `wave_reset` has priority over everything:
  - `alive` becomes all-ones;
  - `hit`, `score_inc` and `busy` clear;
  - the FSM goes to IDLE;
  - a scan in progress is aborted and no kill is applied.
- Already-dead cells never match.

## Timing
- Reset values:
  - `alive` = all ones;
  - `hit`, `score_inc`, `busy`, `all_dead` = 0;
  - `hit_row`, `hit_col`, `score_pts` = 0;
  - FSM = IDLE.
- `frame_tick` sampled at edge T: cell `k` is evaluated in the cycle after edge T+k. A kill on cell `k` is visible on `hit`/`alive`/`score_inc` after edge T+1+k.
- Worst-case scan = ROWS*COLS cycles (55). Frame period must exceed this.
- `busy` = 1 exactly while the FSM is in SCAN.
- `all_dead` updates one cycle after `alive`.
- `score_inc` is high for exactly one `Clk`.

## Structure
- Package `invaders_pkg` holds:
  - the grid/pitch/size defaults;
  - the screen bounds 640/480;
  - the FSM state enum;
  - the function `row_points(row)` returning the 6-bit point value.
- Sub-module `alien_box_overlap`: combinational; inputs are the missile box and the alien origin; output is the overlap bit. It is instantiated once, and the cell counter muxes the alien origin into it.

## Test plan
All scenarios use `gridx=100`, `gridy=50`, default parameters.
- Missile (105,118), size 8, `frame_tick` at edge T:
  - alien (4,0) box is (100,114);
  - bit 44 clears after edge T+45;
  - `hit`=1, `hit_row=4`, `hit_col=0`, `score_pts=10`, one `score_inc` pulse.
- Same missile on the next frame: no match on dead bit 44; `hit` drops after the tick; scan runs 55 cycles then `busy`=0.
- Missile (641,481): `busy` never rises; `hit` stays 0; `alive` unchanged.
- Missile x=116 (exactly at the alien-0 right edge), y=118: no overlap in columns 0 or 1; no kill.
- Missile (105,50), size 8: kill at row 0, col 0, `score_pts=30`.
- Assert `wave_reset` 10 cycles into a scan that would hit cell 20: no kill; `alive` = all ones; `busy`=0 the next cycle.
